// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg -- shared constants, hex segment table and leading-zero helper
// for the seven-segment scanner. Rev 1.0
`default_nettype none

package seven_seg_pkg;

  localparam int SEG_WIDTH  = 7;
  localparam int MAX_DIGITS = 8;

  // Segment order {a,b,c,d,e,f,g}, bit 6 = a, active-high.
  localparam logic [SEG_WIDTH-1:0] HEX_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Bit k set when nibble k and every higher nibble are zero; digit 0 never set.
  function automatic logic [MAX_DIGITS-1:0] leading_zero_mask(
    input logic [4*MAX_DIGITS-1:0] nibbles,
    input int                      num_digits
  );
    logic                  all_zero;
    logic [MAX_DIGITS-1:0] mask;
    mask     = '0;
    all_zero = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < num_digits) begin
        all_zero = all_zero & (nibbles[4*k +: 4] == 4'h0);
        mask[k]  = all_zero;
      end
    end
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_hex_decoder.sv
// seven_segment_hex_decoder -- combinational 4-bit to 7-segment lookup. Rev 1.0
`default_nettype none

module seven_segment_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0]           nibble_i,
  output logic [SEG_WIDTH-1:0] seg_o
);

  assign seg_o = HEX_TABLE[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner -- time-multiplexed N-digit hex display driver with
// frame-synchronous shadow update. Optional macro: LEADING_ZERO_BLANK_EN. Rev 1.0
`default_nettype none

module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [SEG_WIDTH-1:0]    seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    update_pending,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d, disp_blank_q, disp_blank_d;
  logic                  pending_q, pending_d, frame_q, frame_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_WIDTH-1:0]  seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  scan_tick, wrap_tick, digit_dark;
  logic [3:0]            cur_nibble;
  logic [SEG_WIDTH-1:0]  cur_pattern;

  assign scan_tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign wrap_tick  = scan_tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign cur_nibble = 4'(disp_val_q >> {idx_q, 2'b00});

`ifdef LEADING_ZERO_BLANK_EN
  logic [4*MAX_DIGITS-1:0] val_ext;
  logic [MAX_DIGITS-1:0]   lz_mask;

  always_comb begin
    val_ext             = '0;
    val_ext[VAL_W-1:0]  = disp_val_q;
    lz_mask             = leading_zero_mask(val_ext, NUM_DIGITS);
  end

  assign digit_dark = 1'(disp_blank_q >> idx_q) | 1'(lz_mask >> idx_q);
`else
  assign digit_dark = 1'(disp_blank_q >> idx_q);
`endif

  seven_segment_hex_decoder u_hex_decoder (
    .nibble_i (cur_nibble),
    .seg_o    (cur_pattern)
  );

  always_comb begin
    cnt_d          = scan_tick ? '0 : cnt_q + CNT_W'(1);
    idx_d          = idx_q;
    shadow_val_d   = shadow_val_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    disp_val_d     = disp_val_q;
    disp_dp_d      = disp_dp_q;
    disp_blank_d   = disp_blank_q;
    pending_d      = pending_q;
    frame_d        = wrap_tick;

    if (wrap_tick)      idx_d = '0;
    else if (scan_tick) idx_d = idx_q + IDX_W'(1);

    if (load) begin
      shadow_val_d   = value;
      shadow_dp_d    = dp_in;
      shadow_blank_d = blank_in;
    end

    // A load coinciding with the wrap bypasses the shadow so it is not a frame late.
    if (wrap_tick) begin
      disp_val_d   = load ? value    : shadow_val_q;
      disp_dp_d    = load ? dp_in    : shadow_dp_q;
      disp_blank_d = load ? blank_in : shadow_blank_q;
      pending_d    = 1'b0;
    end else if (load) begin
      pending_d    = 1'b1;
    end

    an_d  = digit_dark ? '0 : (NUM_DIGITS'(1) << idx_q);
    seg_d = digit_dark ? '0 : cur_pattern;
    dp_d  = digit_dark ? 1'b0 : 1'(disp_dp_q >> idx_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_val_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      disp_val_q     <= '0;
      disp_dp_q      <= '0;
      disp_blank_q   <= '0;
      pending_q      <= 1'b0;
      frame_q        <= 1'b0;
      an_q           <= '0;
      seg_q          <= '0;
      dp_q           <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_val_q   <= shadow_val_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      disp_val_q     <= disp_val_d;
      disp_dp_q      <= disp_dp_d;
      disp_blank_q   <= disp_blank_d;
      pending_q      <= pending_d;
      frame_q        <= frame_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an             = an_q;
  assign seg_out        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp_out         = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
  assign update_pending = pending_q;
  assign frame_tick     = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner -- directed checks of scan timing, load handshake,
// decode, blanking and polarity (second instance with SEG_ACTIVE_LOW = 1).
`default_nettype none

module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;

  logic [6:0]  seg_out, seg_out_n;
  logic        dp_out, dp_out_n;
  logic [3:0]  an, an_n;
  logic        update_pending, update_pending_n;
  logic        frame_tick, frame_tick_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0)) u_dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .seg_out(seg_out), .dp_out(dp_out), .an(an),
    .update_pending(update_pending), .frame_tick(frame_tick)
  );

  seven_segment_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)) u_dut_n (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .seg_out(seg_out_n), .dp_out(dp_out_n), .an(an_n),
    .update_pending(update_pending_n), .frame_tick(frame_tick_n)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val("frame_timeout", 32'd0, 32'd1);
  endtask

  // Called right at the frame_tick negedge; samples mid-way through each digit slot.
  task automatic check_frame(input string tag, input logic [27:0] segs,
                             input logic [3:0] vis, input logic [3:0] dps);
    for (int k = 0; k < 4; k++) begin
      logic [6:0] es;
      logic [3:0] ea;
      es = segs[7*k +: 7];
      ea = vis[k] ? (4'b0001 << k) : 4'b0000;
      tick(k == 0 ? 2 : 4);
      check_val({tag, "_an"},    {28'd0, an},           {28'd0, ea});
      check_val({tag, "_seg"},   {25'd0, seg_out},      {25'd0, es});
      check_val({tag, "_dp"},    {31'd0, dp_out},       {31'd0, dps[k]});
      check_val({tag, "_seg_n"}, {25'd0, seg_out_n},    {25'd0, ~es});
      check_val({tag, "_dp_n"},  {31'd0, dp_out_n},     {31'd0, ~dps[k]});
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    load = 1'b1; value = v; dp_in = d; blank_in = b;
  endtask

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S7 = 7'b1110000, S8 = 7'b1111111, SA = 7'b1110111,
                         SC = 7'b1001110;

  initial begin
    // Reset state
    tick(3);
    check_val("rst_an",      {28'd0, an},        32'd0);
    check_val("rst_seg",     {25'd0, seg_out},   32'd0);
    check_val("rst_seg_n",   {25'd0, seg_out_n}, 32'h7F);
    check_val("rst_dp_n",    {31'd0, dp_out_n},  32'd1);
    check_val("rst_pending", {31'd0, update_pending}, 32'd0);
    check_val("rst_frame",   {31'd0, frame_tick}, 32'd0);
    reset = 1'b0;

    // Free-running scan after release
    for (int k = 1; k <= 32; k++) begin
      tick(1);
      check_val("scan_an",    {28'd0, an},         32'd1 << (((k - 1) / 4) % 4));
      check_val("scan_seg",   {25'd0, seg_out},    {25'd0, S0});
      check_val("scan_frame", {31'd0, frame_tick}, (k % 16 == 0) ? 32'd1 : 32'd0);
    end

    // Load and decode, held in shadow until the wrap
    wait_frame();
    do_load(16'hA5C3, 4'b0100, 4'b0000);
    tick(1);
    load = 1'b0;
    check_val("ld_pending", {31'd0, update_pending}, 32'd1);
    tick(1);
    check_val("ld_hold_seg", {25'd0, seg_out}, {25'd0, S0});
    wait_frame();
    check_val("ld_cleared", {31'd0, update_pending}, 32'd0);
    check_frame("a5c3", {SA, S5, SC, S3}, 4'b1111, 4'b0100);

    // Last of two loads wins
    wait_frame();
    do_load(16'h1111, 4'b0000, 4'b0000);
    tick(1);
    do_load(16'h2222, 4'b0000, 4'b0000);
    tick(1);
    load = 1'b0;
    check_val("dbl_pending", {31'd0, update_pending}, 32'd1);
    wait_frame();
    check_frame("2222", {S2, S2, S2, S2}, 4'b1111, 4'b0000);

    // Load exactly on the wrap tick bypasses the shadow
    wait_frame();
    tick(15);
    check_val("wrap_pre_pending", {31'd0, update_pending}, 32'd0);
    do_load(16'h7777, 4'b0000, 4'b0000);
    tick(1);
    load = 1'b0;
    check_val("wrap_frame",   {31'd0, frame_tick},     32'd1);
    check_val("wrap_pending", {31'd0, update_pending}, 32'd0);
    tick(1);
    check_val("wrap_an",  {28'd0, an},      32'd1);
    check_val("wrap_seg", {25'd0, seg_out}, {25'd0, S7});
    check_val("wrap_pending2", {31'd0, update_pending}, 32'd0);

    // Blanking
    wait_frame();
    do_load(16'h8888, 4'b0000, 4'b1010);
    tick(1);
    load = 1'b0;
    wait_frame();
    check_frame("blank", {7'd0, S8, 7'd0, S8}, 4'b0101, 4'b0000);

    // Reset mid-operation with a pending load at index 2
    wait_frame();
    tick(8);
    do_load(16'h1234, 4'b1111, 4'b0000);
    tick(1);
    load = 1'b0;
    check_val("mid_pending", {31'd0, update_pending}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("mid_an",      {28'd0, an},             32'd0);
    check_val("mid_seg",     {25'd0, seg_out},        32'd0);
    check_val("mid_seg_n",   {25'd0, seg_out_n},      32'h7F);
    check_val("mid_pending0", {31'd0, update_pending}, 32'd0);
    check_val("mid_frame",   {31'd0, frame_tick},     32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    check_val("post_an",  {28'd0, an},      32'd1);
    check_val("post_seg", {25'd0, seg_out}, {25'd0, S0});
    check_val("post_dp",  {31'd0, dp_out},  32'd0);
    check_val("post_pending", {31'd0, update_pending}, 32'd0);
    tick(4);
    check_val("post_an1",  {28'd0, an},      32'd2);
    check_val("post_seg1", {25'd0, seg_out}, {25'd0, S0});

    // Leading zeros, value 0x0040
    wait_frame();
    do_load(16'h0040, 4'b0000, 4'b0000);
    tick(1);
    load = 1'b0;
    wait_frame();
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("lz", {7'd0, 7'd0, S4, S0}, 4'b0011, 4'b0000);
`else
    check_frame("lz", {S0, S0, S4, S0}, 4'b1111, 4'b0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
